// File: rtl/mult_lut_seq.sv
// Sequential radix-4 LUT multiplier: one 2-bit digit of the multiplier per clock,
// start/done handshake, held result, per-operation signed/unsigned mode.
module mult_lut_seq #(
    parameter int WIDTH = 16  // even, >= 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iStart,
    input  logic                 iSigned,
    input  logic [WIDTH-1:0]     iDato_A,
    input  logic [WIDTH-1:0]     iDato_B,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [2*WIDTH-1:0]   oResult_Mux
);

    localparam int PW   = 2 * WIDTH;
    localparam int NDIG = WIDTH / 2;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q;
    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    result_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] mag_a_d, mag_b_d;
    logic [PW-1:0]    pp_d, acc_d, neg_res_d;
    logic             neg_d;

    // Magnitudes fit unsigned in WIDTH bits, including the most negative operand.
    always_comb begin
        mag_a_d = (iSigned && iDato_A[WIDTH-1]) ? (~iDato_A + 1'b1) : iDato_A;
        mag_b_d = (iSigned && iDato_B[WIDTH-1]) ? (~iDato_B + 1'b1) : iDato_B;
        neg_d   = iSigned & (iDato_A[WIDTH-1] ^ iDato_B[WIDTH-1]);
    end

    // mcand_q is pre-shifted by 2 each step, so the LUT entry already carries the
    // digit weight and no barrel shifter is needed.
    always_comb begin
        pp_d = '0;
        case (mplier_q[1:0])
            2'd0: pp_d = '0;
            2'd1: pp_d = mcand_q;
            2'd2: pp_d = mcand_q << 1;
            2'd3: pp_d = mcand_q + (mcand_q << 1);
            default: pp_d = '0;
        endcase
        acc_d     = acc_q + pp_d;
        neg_res_d = ~acc_q + 1'b1;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (iStart) begin
                        mcand_q  <= {{WIDTH{1'b0}}, mag_a_d};
                        mplier_q <= mag_b_d;
                        neg_q    <= neg_d;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 2;
                    mplier_q <= mplier_q >> 2;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST)
                        state_q <= FIX;
                end
                FIX: begin
                    // Negating zero yields zero, so no -0 special case.
                    result_q <= neg_q ? neg_res_d : acc_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oBusy       = busy_q;
    assign oDone       = done_q;
    assign oResult_Mux = result_q;

endmodule

// File: tb/tb_mult_lut_seq.sv
// Directed + random bench for mult_lut_seq (WIDTH=16) with a result scoreboard
// and a monitor that checks each done pulse and result hold between pulses.
module tb_mult_lut_seq;

    logic        Clock;
    logic        Reset;
    logic        iStart;
    logic        iSigned;
    logic [15:0] iDato_A;
    logic [15:0] iDato_B;
    logic        oBusy;
    logic        oDone;
    logic [31:0] oResult_Mux;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = '0;

    mult_lut_seq #(.WIDTH(16)) dut (
        .Clock(Clock), .Reset(Reset), .iStart(iStart), .iSigned(iSigned),
        .iDato_A(iDato_A), .iDato_B(iDato_B),
        .oBusy(oBusy), .oDone(oDone), .oResult_Mux(oResult_Mux)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic s);
        longint pa, pb, p;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        p  = pa * pb;
        return p[31:0];
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h8000;
            3: return 16'hFFFF;
            4: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (oBusy === 1'b1 && n < 100) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 100) chk("idle_timeout", oBusy, 0);
    endtask

    // Drives one start pulse at a negedge; returns at the next negedge with
    // operands scrambled so late changes must not reach the operation.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                            input logic [31:0] exp);
        wait_idle();
        iStart = 1'b1; iDato_A = a; iDato_B = b; iSigned = s;
        exp_q.push_back(exp);
        @(negedge Clock);
        iStart = 1'b0; iDato_A = 16'($urandom); iDato_B = 16'($urandom); iSigned = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge Clock);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        Reset = 1'b0; iStart = 1'b0; iSigned = 1'b0; iDato_A = '0; iDato_B = '0;

        fork
            forever begin
                @(negedge Clock);
                if (Reset) begin
                    if (oDone) begin
                        if (exp_q.size() == 0) chk("unexpected_done", oDone, 0);
                        else chk("result", oResult_Mux, exp_q.pop_front());
                        last_res = oResult_Mux;
                    end else begin
                        chk("hold", oResult_Mux, last_res);
                    end
                end else begin
                    last_res = '0;
                end
            end
        join_none

        #1;
        chk("rst_busy", oBusy, 0);
        chk("rst_done", oDone, 0);
        chk("rst_result", oResult_Mux, 0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);

        // Latency and busy window: 9 busy cycles, then done.
        start_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        for (int i = 0; i < 9; i++) begin
            chk("lat_busy", oBusy, 1);
            chk("lat_nodone", oDone, 0);
            @(negedge Clock);
        end
        chk("lat_done", oDone, 1);
        chk("lat_busy_low", oBusy, 0);

        start_op(16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1);
        start_op(16'hFFFD, 16'h0005, 1'b0, 32'h0004FFF1);
        start_op(16'h8000, 16'h8000, 1'b1, 32'h40000000);
        start_op(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000);
        start_op(16'h0000, 16'hFFFF, 1'b1, 32'h00000000);
        start_op(16'hFFFF, 16'h0000, 1'b1, 32'h00000000);
        drain();

        // Starts during CALC and FIX must be ignored.
        start_op(16'd3, 16'd4, 1'b0, 32'h0000000C);
        @(negedge Clock);
        iStart = 1'b1; iDato_A = 16'd7; iDato_B = 16'd7;
        @(negedge Clock);
        iStart = 1'b0;
        repeat (6) @(negedge Clock);
        chk("fix_busy", oBusy, 1);
        iStart = 1'b1;
        @(negedge Clock);
        iStart = 1'b0;
        chk("fix_done", oDone, 1);
        repeat (3) @(negedge Clock);
        chk("ignored_start_busy", oBusy, 0);
        start_op(16'd7, 16'd7, 1'b0, 32'h00000031);
        drain();

        // Asynchronous reset mid-operation.
        start_op(16'd100, 16'd200, 1'b0, 32'd20000);
        repeat (3) @(negedge Clock);
        #2 Reset = 1'b0;
        #1;
        chk("abort_busy", oBusy, 0);
        chk("abort_done", oDone, 0);
        chk("abort_result", oResult_Mux, 0);
        exp_q.delete();
        @(negedge Clock);
        Reset = 1'b1;
        start_op(16'd6, 16'd7, 1'b0, 32'h0000002A);
        drain();

        // Back-to-back accept in the done cycle.
        start_op(16'd2, 16'd3, 1'b0, 32'd6);
        start_op(16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE);
        drain();

        for (int k = 0; k < 2000; k++) begin
            logic [15:0] a, b;
            logic s;
            a = pick();
            b = pick();
            s = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge Clock);
            start_op(a, b, s, ref_mul(a, b, s));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
